// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types for the 3-stage pipeline.
// Holds the IF/EX bundle and the fetch redirect states.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RV_NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t pc4;
    logic  mal;
    logic  fault;
  } fetch_latch_t;

  typedef enum logic {
    RD_RUN,
    RD_DISCARD
  } redirect_state_t;

endpackage

// File: rtl/stage3_redirect_tracker.sv
// Tracks a redirect that lands while an instruction read is in flight.
// While discarding, the late read data is dropped and no new read issues.
module stage3_redirect_tracker
  import rv32i_types_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic redirect,
  input  logic rd_busy,
  input  logic imem_busy,
  output logic discard
);

  redirect_state_t state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RD_RUN;
      discard <= 1'b0;
    end else begin
      unique case (state)
        RD_RUN: begin
          if (redirect && rd_busy) begin
            state   <= RD_DISCARD;
            discard <= 1'b1;
          end
        end
        RD_DISCARD: begin
          if (!imem_busy) begin
            state   <= RD_RUN;
            discard <= 1'b0;
          end
        end
        default: begin
          state   <= RD_RUN;
          discard <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/stage3_fetch_unit.sv
// Fetch stage: owns the PC, issues instruction reads
// and drives the IF/EX latch under hazard control.
module stage3_fetch_unit
  import rv32i_types_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0200,
  parameter word_t NOP_INSN = RV_NOP_INSN
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pc_en,
  input  logic        npc_sel,
  input  logic [31:0] brj_addr,
  input  logic        insert_priv_pc,
  input  logic [31:0] priv_pc,
  input  logic        iren,
  input  logic        suppress_iren,
  input  logic        if_ex_stall,
  input  logic        if_ex_flush,
  input  logic        imem_busy,
  input  logic [31:0] imem_rdata,
  input  logic        imem_fault,
  output logic [31:0] imem_addr,
  output logic        imem_ren,
  output logic [31:0] pc_f,
  output logic        i_mem_busy,
  output logic        fe_valid,
  output logic [31:0] fe_instr,
  output logic [31:0] fe_pc,
  output logic [31:0] fe_pc4,
  output logic        fe_mal_insn,
  output logic        fe_fault_insn
);

  word_t        pc_q;
  word_t        pc4;
  word_t        npc;
  word_t        addr_q;
  logic         hold_q;
  logic         discard;
  logic         redirect;
  logic         req;
  logic         aligned;
  fetch_latch_t lat_q;
  fetch_latch_t lat_d;

  assign pc4      = pc_q + 32'd4;
  assign aligned  = (pc_q[1:0] == 2'b00);
  assign redirect = pc_en & (insert_priv_pc | npc_sel);
  assign req      = iren & ~suppress_iren & ~discard;

  assign imem_ren   = req & aligned;
  assign imem_addr  = hold_q ? addr_q : {pc_q[31:2], 2'b00};
  assign i_mem_busy = (imem_ren & imem_busy) | discard;
  assign pc_f       = pc_q;

  stage3_redirect_tracker u_tracker (
    .CLK      (CLK),
    .RST      (RST),
    .redirect (redirect),
    .rd_busy  (imem_ren & imem_busy),
    .imem_busy(imem_busy),
    .discard  (discard)
  );

  always_comb begin
    npc = pc4;
    unique case (1'b1)
      insert_priv_pc:             npc = priv_pc;
      (~insert_priv_pc & npc_sel): npc = brj_addr;
      default:                    npc = pc4;
    endcase
  end

  // Bubbles keep the old slot PC; only valid/instr/flags are cleared.
  always_comb begin
    lat_d = lat_q;
    unique case (1'b1)
      if_ex_flush: begin
        lat_d.valid = 1'b0;
        lat_d.instr = NOP_INSN;
        lat_d.mal   = 1'b0;
        lat_d.fault = 1'b0;
      end
      (~if_ex_flush & if_ex_stall): begin
        lat_d = lat_q;
      end
      (~if_ex_flush & ~if_ex_stall & imem_ren & ~imem_busy): begin
        lat_d.valid = 1'b1;
        lat_d.instr = imem_rdata;
        lat_d.pc    = pc_q;
        lat_d.pc4   = pc4;
        lat_d.mal   = 1'b0;
        lat_d.fault = imem_fault;
      end
      (~if_ex_flush & ~if_ex_stall & req & ~aligned): begin
        lat_d.valid = 1'b1;
        lat_d.instr = NOP_INSN;
        lat_d.pc    = pc_q;
        lat_d.pc4   = pc4;
        lat_d.mal   = 1'b1;
        lat_d.fault = 1'b0;
      end
      default: begin
        lat_d.valid = 1'b0;
        lat_d.instr = NOP_INSN;
        lat_d.mal   = 1'b0;
        lat_d.fault = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q   <= RESET_PC;
      hold_q <= 1'b0;
      addr_q <= '0;
      lat_q  <= '{valid: 1'b0, instr: NOP_INSN, pc: '0,
                  pc4: '0, mal: 1'b0, fault: 1'b0};
    end else begin
      if (pc_en) pc_q <= npc;
      hold_q <= imem_busy & (imem_ren | hold_q);
      addr_q <= imem_addr;
      lat_q  <= lat_d;
    end
  end

  assign fe_valid      = lat_q.valid;
  assign fe_instr      = lat_q.instr;
  assign fe_pc         = lat_q.pc;
  assign fe_pc4        = lat_q.pc4;
  assign fe_mal_insn   = lat_q.mal;
  assign fe_fault_insn = lat_q.fault;

endmodule
